// File: rtl/ifu_stream.sv
// ifu_stream: stall-aware instruction fetch unit.
//
// Holds the fetch PC and a byte-organised instruction memory. Each cycle it
// presents one instruction to decode through a valid/ready output register.
// Later pipeline stages steer fetch with a single redirect port. A redirect
// squashes whatever instruction is currently presented.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   im_we          instruction memory word-write enable (program load)
//   im_waddr       byte address of the write (bits [1:0] ignored)
//   im_wdata       write word, stored in the same byte order as fetch
//   redirect_valid later stage requests a PC change
//   redirect_pc    redirect target address
//   out_ready      decode accepts the presented instruction
//   out_valid      out_instr / out_pc / out_pc4 are valid
//   out_instr      fetched instruction
//   out_pc         address of out_instr
//   out_pc4        out_pc + 4 (link value)
//   fetch_err      sticky misaligned-redirect flag
//
// Configuration macro: IFU_STREAM_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect sets fetch_err and halts fetch until reset
//   undefined : redirect targets are forced to word alignment, fetch_err = 0
module ifu_stream #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          IM_BYTES   = 4096,
    parameter int          ADDR_W     = 12,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              im_we,
    input  logic [ADDR_W-1:0] im_waddr,
    input  logic [31:0]       im_wdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc4,
    output logic              fetch_err
);

    // Byte-wide instruction memory; deliberately not reset.
    logic [7:0]        mem [IM_BYTES];

    logic [31:0]       pc;
    logic [31:0]       pc_next;
    logic              valid_next;
    logic [31:0]       instr_next;
    logic [31:0]       out_pc_next;

    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic [7:0]        fetch_byte [4];
    logic [7:0]        wr_byte [4];
    logic [31:0]       fetch_word;

    logic              advance;
    logic              redirect_take;
    logic              fetch_take;
    logic [31:0]       redirect_target;

    // Only the low ADDR_W bits of the PC select memory; higher bits alias.
    assign rd_base = pc[ADDR_W-1:0];

    // Writes always land on a whole word, so the two low address bits drop out.
    assign wr_base = im_waddr & ~ADDR_W'(3);

    // Byte k of the fetch word sits at (pc + k) mod IM_BYTES; the ADDR_W-bit
    // add wraps naturally past the end of memory.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            fetch_byte[k] = mem[rd_base + ADDR_W'(k)];
        end
    end

    // Assemble the fetch word and split the write word with the same byte order
    // so that a word written at A reads back unchanged from A.
    always_comb begin
        if (BIG_ENDIAN) begin
            fetch_word = {fetch_byte[0], fetch_byte[1], fetch_byte[2], fetch_byte[3]};
            wr_byte[0] = im_wdata[31:24];
            wr_byte[1] = im_wdata[23:16];
            wr_byte[2] = im_wdata[15:8];
            wr_byte[3] = im_wdata[7:0];
        end else begin
            fetch_word = {fetch_byte[3], fetch_byte[2], fetch_byte[1], fetch_byte[0]};
            wr_byte[0] = im_wdata[7:0];
            wr_byte[1] = im_wdata[15:8];
            wr_byte[2] = im_wdata[23:16];
            wr_byte[3] = im_wdata[31:24];
        end
    end

    // Program load port. The fetch path reads mem combinationally before this
    // edge updates it, which gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (im_we) begin
            for (int k = 0; k < 4; k++) begin
                mem[wr_base + ADDR_W'(k)] <= wr_byte[k];
            end
        end
    end

    // The output register may load when it is empty or being drained.
    assign advance = !out_valid || out_ready;

`ifdef IFU_STREAM_MISALIGN_TRAP_EN
    logic halted;
    logic halted_next;
    logic err_next;

    // Once halted, redirects are ignored and nothing more is fetched.
    assign redirect_take   = redirect_valid && !halted;
    assign redirect_target = redirect_pc;
    assign fetch_take      = !redirect_take && advance && !halted;

    // A misaligned target still loads the PC, but traps fetch for good.
    always_comb begin
        halted_next = halted;
        err_next    = fetch_err;
        if (redirect_take && (redirect_pc[1:0] != 2'b00)) begin
            halted_next = 1'b1;
            err_next    = 1'b1;
        end
    end

    // Sticky trap state; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            halted    <= halted_next;
            fetch_err <= err_next;
        end
    end
`else
    // Without the trap, targets are silently word-aligned.
    assign redirect_take   = redirect_valid;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign fetch_take      = !redirect_valid && advance;
    assign fetch_err       = 1'b0;
`endif

    // Redirect beats fetch and squashes the presented instruction; a transfer
    // in the same cycle has already happened on the decode side.
    always_comb begin
        pc_next     = pc;
        valid_next  = out_valid;
        instr_next  = out_instr;
        out_pc_next = out_pc;
        if (redirect_take) begin
            pc_next    = redirect_target;
            valid_next = 1'b0;
        end else if (fetch_take) begin
            instr_next  = fetch_word;
            out_pc_next = pc;
            valid_next  = 1'b1;
            pc_next     = pc + 32'd4;
        end
    end

    // Fetch PC and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
        end else begin
            pc        <= pc_next;
            out_valid <= valid_next;
            out_instr <= instr_next;
            out_pc    <= out_pc_next;
        end
    end

    assign out_pc4 = out_pc + 32'd4;

endmodule
